// File: rtl/instr_fetch.sv
// Instruction fetch stage: program-loadable instruction memory, PC sequencer and
// a one-entry valid/ready output register with redirect, halt and idle handling.
module instr_fetch #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     imem_we,
    input  logic [$clog2(DEPTH)-1:0] imem_waddr,
    input  logic [31:0]              imem_wdata,
    input  logic                     run,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              instruction,
    output logic [31:0]              pc_out,
    output logic                     halted
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0] rd_data_s;
    logic [31:0] redir_pc_s;
    logic        can_adv_s;
    logic        in_range_s;

    // Asynchronous read; a write to the same index lands after this edge, so old data is fetched
    assign rd_data_s  = mem_q[pc_q[AW+1:2]];
    assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
    assign can_adv_s  = ~out_valid_q | out_ready;
    assign in_range_s = (pc_q < PC_LIMIT);

    // Program-load port; memory is deliberately outside reset
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[imem_waddr] <= imem_wdata;
        end
    end

    // State, PC and output register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0000_0000;
            pc_out_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and fetch decision; a transferred word clears valid unless replaced
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        out_valid_d = out_valid_q & ~out_ready;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redir_pc_s;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d        = redir_pc_s;
                    out_valid_d = 1'b0;
                end else if (!run) begin
                    if (can_adv_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (!in_range_s) begin
                    if (can_adv_s) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (can_adv_s) begin
                    instr_d     = rd_data_s;
                    pc_out_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + 32'd4;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d        = redir_pc_s;
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    assign out_valid   = out_valid_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic compared each
// cycle against a transaction-level reference model; a DEPTH=4 instance covers halting.
module tb_instr_fetch;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] LIM    = 32'd64;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int MD_IDLE = 0, MD_FETCH = 1, MD_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = 4'd0;
    logic [31:0] imem_wdata = 32'd0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;

    logic        out_valid, halted, out_valid4, halted4;
    logic [31:0] instruction, pc_out, instruction4, pc_out4;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: architectural view only
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pcout;
    logic        m_valid;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] prog [4] = '{32'h00011020, 32'h00401820, 32'h2085FFFF, 32'h20A60001};

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .run(run), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid),
        .instruction(instruction), .pc_out(pc_out), .halted(halted)
    );

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0004)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr[1:0]),
        .imem_wdata(imem_wdata), .run(run), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid4),
        .instruction(instruction4), .pc_out(pc_out4), .halted(halted4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pcout = 32'd0;
    endtask

    // One clock edge of the reference: a waiting word blocks everything but redirect
    task automatic model_edge();
        logic [31:0] tgt;
        logic        waiting;
        tgt     = {redirect_pc[31:2], 2'b00};
        waiting = m_valid && !out_ready;
        if (!rst_n) begin
            model_reset();
        end else if (m_mode == MD_IDLE) begin
            if (redirect_valid) m_pc = tgt;
            else if (run) m_mode = MD_FETCH;
        end else if (m_mode == MD_FETCH) begin
            if (redirect_valid) begin
                m_pc = tgt;
                m_valid = 1'b0;
            end else if (!waiting) begin
                m_valid = 1'b0;
                if (!run) m_mode = MD_IDLE;
                else if (m_pc >= LIM) m_mode = MD_HALT;
                else begin
                    m_instr = m_mem[m_pc >> 2];
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end
            end
        end else if (m_mode == MD_HALT) begin
            if (redirect_valid) begin
                m_pc   = tgt;
                m_mode = MD_FETCH;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic compare_main();
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("halted", 32'(halted), 32'(m_mode == MD_HALT));
        check_eq("pc_out", pc_out, m_pcout);
        check_eq("instruction", instruction, m_instr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_main();
    endtask

    initial begin
        model_reset();
        #12;
        compare_main();
        check_eq("rst4_valid", 32'(out_valid4), 32'd0);
        check_eq("rst4_halted", 32'(halted4), 32'd0);
        check_eq("rst4_pc_out", pc_out4, 32'd0);
        rst_n = 1'b1;

        // Load high words first so the aliased DEPTH=4 instance ends up holding prog
        for (int k = 0; k < 16; k++) begin
            int a;
            a          = (k + 4) % 16;
            imem_we    = 1'b1;
            imem_waddr = 4'(a);
            imem_wdata = (a < 4) ? prog[a] : $urandom();
            step();
        end
        imem_we = 1'b0;

        run = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("first_lat_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("w0_pc", pc_out, 32'd0);
        check_eq("w0_instr", instruction, 32'h00011020);
        step();
        check_eq("w1_pc", pc_out, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", pc_out, 32'd4);
            check_eq("stall_instr", instruction, 32'h00401820);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        check_eq("resume_pc", pc_out, 32'd8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000E;
        step();
        check_eq("redir_flush", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        check_eq("redir_pc", pc_out, 32'd12);
        check_eq("redir_instr", instruction, 32'h20A60001);
        check_eq("d4_w3_pc", pc_out4, 32'd12);

        step();
        check_eq("d4_halted", 32'(halted4), 32'd1);
        check_eq("d4_halt_valid", 32'(out_valid4), 32'd0);
        step();
        check_eq("d4_run_in_halt", 32'(halted4), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        check_eq("d4_unhalt", 32'(halted4), 32'd0);
        check_eq("d4_unhalt_valid", 32'(out_valid4), 32'd0);
        redirect_valid = 1'b0;
        step();
        check_eq("d4_restart_valid", 32'(out_valid4), 32'd1);
        check_eq("d4_restart_pc", pc_out4, 32'd0);
        check_eq("d4_restart_instr", instruction4, 32'h00011020);

        imem_we    = 1'b1;
        imem_waddr = 4'd1;
        imem_wdata = 32'hDEADBEEF;
        step();
        imem_we = 1'b0;
        check_eq("wr_same_pc", pc_out, 32'd4);
        check_eq("wr_same_old", instruction, 32'h00401820);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        step();
        redirect_valid = 1'b0;
        step();
        check_eq("wr_later_pc", pc_out, 32'd4);
        check_eq("wr_later_new", instruction, 32'hDEADBEEF);

        // Asynchronous reset between edges while streaming
        step();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_halted", 32'(halted), 32'd0);
        check_eq("arst_valid4", 32'(out_valid4), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("arst_lat", 32'(out_valid), 32'd0);
        step();
        check_eq("arst_first_pc", pc_out, RST_PC);
        check_eq("arst_mem_kept", instruction, 32'h00011020);
        check_eq("d4_rstpc", pc_out4, 32'd4);
        check_eq("d4_mem_kept", instruction4, 32'hDEADBEEF);

        for (int c = 0; c < 3000; c++) begin
            run            = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 80);
            imem_we        = ($urandom_range(0, 4) == 0);
            imem_waddr     = 4'($urandom_range(0, 15));
            imem_wdata     = $urandom();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
